// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, icache request and IF/ID latch.
// Optional perf counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] PC_INIT  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  input  logic        halt_i,
  output logic [31:0] instr_o,
  output logic [31:0] npc_o,
  output logic        valid_o,
  output logic        halted_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  typedef enum logic {FETCH, HALTED} state_t;

  localparam logic [31:0] PC_RESET = PC_INIT & 32'hFFFF_FFFC;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] instr_next, npc_next;
  logic        valid_next, halted_next;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;
  logic        fetch_inc, bubble_inc;

  assign pc_plus4    = pc + 32'd4;
  assign redirect_pc = target_i & 32'hFFFF_FFFC;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= FETCH;
      pc       <= PC_RESET;
      instr_o  <= NOP_WORD;
      npc_o    <= 32'h0000_0000;
      valid_o  <= 1'b0;
      halted_o <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      instr_o  <= instr_next;
      npc_o    <= npc_next;
      valid_o  <= valid_next;
      halted_o <= halted_next;
    end
  end

  // Redirect outranks halt because a halt seen alongside a redirect is wrong-path.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    instr_next  = instr_o;
    npc_next    = npc_o;
    valid_next  = valid_o;
    halted_next = halted_o;
    iREN        = 1'b0;
    iaddr       = pc;
    fetch_inc   = 1'b0;
    bubble_inc  = 1'b0;
    case (state)
      FETCH: begin
        iREN = 1'b1;
        if (redirect_i) begin
          pc_next    = redirect_pc;
          instr_next = NOP_WORD;
          valid_next = 1'b0;
        end else if (halt_i) begin
          state_next  = HALTED;
          halted_next = 1'b1;
          instr_next  = NOP_WORD;
          valid_next  = 1'b0;
        end else if (stall_i) begin
          bubble_inc = 1'b1;
        end else if (ihit) begin
          instr_next = iload;
          npc_next   = pc_plus4;
          valid_next = 1'b1;
          pc_next    = pc_plus4;
          fetch_inc  = 1'b1;
        end else begin
          instr_next = NOP_WORD;
          valid_next = 1'b0;
          bubble_inc = 1'b1;
        end
      end
      HALTED: begin
        instr_next  = NOP_WORD;
        valid_next  = 1'b0;
        halted_next = 1'b1;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt_o  <= 32'h0000_0000;
      bubble_cnt_o <= 32'h0000_0000;
    end else begin
      if (fetch_inc)  fetch_cnt_o  <= fetch_cnt_o + 32'd1;
      if (bubble_inc) bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = fetch_inc ^ bubble_inc;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver predicts IF/ID contents into a
// queue and an independent monitor pops and compares whenever valid_o is high.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, stall_i, redirect_i, halt_i;
  logic [31:0] iload, target_i;
  logic        iREN, valid_o, halted_o;
  logic [31:0] iaddr, instr_o, npc_o;
  logic        wrap_iren, wrap_valid, wrap_halted;
  logic [31:0] wrap_iaddr, wrap_instr, wrap_npc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt, wrap_fetch_cnt, wrap_bubble_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  logic [63:0] exp_q[$];
  logic [31:0] m_pc, m_instr, m_npc;
  logic        m_valid, m_halted;

  always #5 CLK = ~CLK;

  fetch_stage #(.PC_INIT(32'h0000_0000), .NOP_WORD(NOP)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .iREN(iREN), .iaddr(iaddr),
    .stall_i(stall_i), .redirect_i(redirect_i), .target_i(target_i), .halt_i(halt_i),
    .instr_o(instr_o), .npc_o(npc_o), .valid_o(valid_o), .halted_o(halted_o)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt_o(fetch_cnt), .bubble_cnt_o(bubble_cnt)
`endif
  );

  fetch_stage #(.PC_INIT(32'hFFFF_FFF8), .NOP_WORD(NOP)) dut_wrap (
    .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .iREN(wrap_iren), .iaddr(wrap_iaddr),
    .stall_i(stall_i), .redirect_i(redirect_i), .target_i(target_i), .halt_i(halt_i),
    .instr_o(wrap_instr), .npc_o(wrap_npc), .valid_o(wrap_valid), .halted_o(wrap_halted)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt_o(wrap_fetch_cnt), .bubble_cnt_o(wrap_bubble_cnt)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every IF/ID slot holding a real instruction must match the head of the queue.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("ifid_unexpected_valid", {instr_o, npc_o}, 64'h0);
        end else begin
          checkOutput("ifid_instr_npc", {instr_o, npc_o}, exp_q.pop_front());
        end
      end
    end
  end

  task automatic modelReset();
    m_pc = 32'h0000_0000; m_instr = NOP; m_npc = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  task automatic doReset();
    RST = 1'b1;
    ihit = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; halt_i = 1'b0;
    iload = 32'h0; target_i = 32'h0;
    @(negedge CLK);
    RST = 1'b0;
    modelReset();
  endtask

  // Checks the state left by the previous edge, then drives one cycle of inputs.
  task automatic applyStimulus(input logic hit, input logic [31:0] load, input logic stall,
                               input logic redir, input logic [31:0] tgt, input logic halt);
    checkOutput("iren", {63'h0, iREN}, {63'h0, ~m_halted});
    checkOutput("halted", {63'h0, halted_o}, {63'h0, m_halted});
    checkOutput("valid", {63'h0, valid_o}, {63'h0, m_valid});
    if (!m_halted) checkOutput("iaddr", {32'h0, iaddr}, {32'h0, m_pc});
    if (!m_valid) checkOutput("bubble_instr", {32'h0, instr_o}, {32'h0, NOP});
    ihit = hit; iload = load; stall_i = stall; redirect_i = redir; target_i = tgt; halt_i = halt;
    if (!m_halted) begin
      if (redir) begin
        m_pc = tgt & 32'hFFFF_FFFC; m_instr = NOP; m_valid = 1'b0;
      end else if (halt) begin
        m_halted = 1'b1; m_instr = NOP; m_valid = 1'b0;
      end else if (stall) begin
        // IF/ID holds its contents
      end else if (hit) begin
        m_instr = load; m_npc = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end else begin
        m_instr = NOP; m_valid = 1'b0;
      end
      if (m_valid) exp_q.push_back({m_instr, m_npc});
    end
    @(negedge CLK);
  endtask

  task automatic hitCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, m_pc ^ XOR_KEY, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  logic [31:0] wrap_exp [3];

  initial begin
    RST = 1'b1;
    ihit = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; halt_i = 1'b0;
    iload = 32'h0; target_i = 32'h0;
    wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0000_0000;
    @(negedge CLK);
    doReset();
    checkOutput("reset_npc", {32'h0, npc_o}, 64'h0);

    $display("[TB] T1 streaming hits");
    hitCycles(2);

    $display("[TB] T2 three misses at pc 8");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
    hitCycles(1);

    $display("[TB] T3 stall with ihit");
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 1'b0);
    hitCycles(2);

    $display("[TB] T4 redirect during stall");
    applyStimulus(1'b1, 32'hBAD0_0000, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
    hitCycles(2);

    $display("[TB] T5 halt");
    applyStimulus(1'b1, 32'hBAD0_0001, 1'b0, 1'b1, 32'h0000_0020, 1'b1);
    applyStimulus(1'b1, m_pc ^ XOR_KEY, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 32'hBAD0_0002, 1'b0, 1'b1, 32'h0000_0040, 1'b0);
    checkOutput("halt_pc_frozen", {32'h0, iaddr}, {32'h0, 32'h0000_0020});
    doReset();

    $display("[TB] T6 pc wrap");
    for (int i = 0; i < 3; i++) begin
      checkOutput("wrap_iaddr", {32'h0, wrap_iaddr}, {32'h0, wrap_exp[i]});
      applyStimulus(1'b1, m_pc ^ XOR_KEY, 1'b0, 1'b0, 32'h0, 1'b0);
    end
    checkOutput("wrap_iaddr_after", {32'h0, wrap_iaddr}, {32'h0, 32'h0000_0004});
    checkOutput("wrap_npc", {32'h0, wrap_npc}, {32'h0, 32'h0000_0004});
    checkOutput("wrap_valid", {63'h0, wrap_valid}, 64'h1);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("wrap_fetch_cnt", {32'h0, wrap_fetch_cnt}, 64'd3);
    checkOutput("fetch_cnt", {32'h0, fetch_cnt}, 64'd3);
`endif
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("scoreboard_drained", {32'h0, 32'(exp_q.size())}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
